if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 25 ++
 rtl/if_id_buffer_entry.sv | 23 ++
 rtl/if_id_buffer.sv | 112 +++++++++++
 tb/tb_if_id_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared CPU definitions: halt opcode, IF/ID FSM encoding, buffer entry layout.
package if_id_buffer_pkg;

  // Opcode in instr[15:12] that stops fetch.
  localparam logic [3:0] HLT_OPC_DEFAULT = 4'hF;

  // Number of slots in the fetch/decode skid buffer.
  localparam int unsigned BUF_DEPTH = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcs;
  } entry_t;

  // True when the instruction carries the given halt opcode.
  function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opc);
    return (instr[15:12] == opc);
  endfunction

endpackage

// File: rtl/if_id_buffer_entry.sv
// One buffer slot: a 32-bit {instr, pcs} register with write enable.
module if_id_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  // Capture the incoming pair when selected; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 32'h0000_0000;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer with halt detection and flush.
// Fetch-side ready depends only on local state so decode stalls never
// form a combinational path back into fetch.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter logic [3:0] HLT_OPC = HLT_OPC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pcs,
  output logic        if_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pcs,
  input  logic        id_ready,
  input  logic        flush,
  output logic        halted
);

  fsm_state_t  r_state;
  fsm_state_t  w_state_next;
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;

  logic        w_push;
  logic        w_pop;
  entry_t      w_wr_data;
  entry_t      w_head;
  logic [31:0] w_entry_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] w_entry_we;

  assign w_push    = if_valid && if_ready;
  assign w_pop     = id_valid && id_ready;
  assign w_wr_data = '{instr: if_instr, pcs: if_pcs};

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      // Flush suppresses the write so a discarded instruction never lands.
      assign w_entry_we[gi] = w_push && !flush && (r_wr_ptr == 1'(gi));

      if_id_entry u_entry (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_entry_we[gi]),
        .i_d  (w_wr_data),
        .o_q  (w_entry_q[gi])
      );
    end
  endgenerate

  assign w_head   = entry_t'(w_entry_q[r_rd_ptr]);
  assign id_valid = (r_count != 2'd0);
  assign id_instr = id_valid ? w_head.instr : 16'h0000;
  assign id_pcs   = id_valid ? w_head.pcs   : 16'h0000;
  assign if_ready = (r_count != 2'd2) && (r_state == ST_RUN);
  assign halted   = (r_state == ST_HALT);

  // Occupancy and pointer bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_count  <= r_count + 2'd1;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        2'b01: begin
          r_count  <= r_count - 2'd1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        2'b11: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a halt push stops fetch; only flush (or reset) resumes it.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_RUN;
    end else if ((r_state == ST_RUN) && w_push && is_halt(if_instr, HLT_OPC)) begin
      w_state_next = ST_HALT;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus queues expected pairs,
// a negedge monitor checks each pair as decode consumes it.
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pcs;
  logic        if_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pcs;
  logic        id_ready;
  logic        flush;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  if_id_buffer #(.HLT_OPC(4'hF)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pcs   (if_pcs),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_pcs   (id_pcs),
    .id_ready (id_ready),
    .flush    (flush),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                     input logic idr, input logic fl);
    @(posedge clk);
    #1;
    if_valid = v;
    if_instr = ins;
    if_pcs   = pc;
    id_ready = idr;
    flush    = fl;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  // Push an accepted pair and record it as expected output.
  task automatic push(input logic [15:0] ins, input logic [15:0] pc, input logic idr);
    cyc(1'b1, ins, pc, idr, 1'b0);
    exp_q.push_back({ins, pc});
  endtask

  // Monitor: a pop happens at the coming edge when these hold mid-cycle.
  always @(negedge clk) begin
    if (!rst && !flush && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %h with empty scoreboard", id_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_instr", id_instr, e[31:16]);
        chk("pop_pcs", id_pcs, e[15:0]);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    if_valid = 1'b0;
    if_instr = 16'h0000;
    if_pcs   = 16'h0000;
    id_ready = 1'b0;
    flush    = 1'b0;

    // Reset values while reset is held.
    #3;
    chk("rst_if_ready", {15'd0, if_ready}, 16'd1);
    chk("rst_id_valid", {15'd0, id_valid}, 16'd0);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_id_pcs", id_pcs, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single push, decode stalled: visible one cycle later.
    push(16'h1234, 16'h0002, 1'b0);
    idle();
    @(negedge clk);
    chk("a_id_valid", {15'd0, id_valid}, 16'd1);
    chk("a_id_instr", id_instr, 16'h1234);
    chk("a_id_pcs", id_pcs, 16'h0002);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("a_empty", {15'd0, id_valid}, 16'd0);

    // Fill to two; third offer must be refused.
    push(16'h1111, 16'h0004, 1'b0);
    push(16'h2222, 16'h0006, 1'b0);
    cyc(1'b1, 16'h3333, 16'h0008, 1'b0, 1'b0);
    @(negedge clk);
    chk("b_if_ready_full", {15'd0, if_ready}, 16'd0);
    chk("b_id_instr", id_instr, 16'h1111);
    idle();
    @(negedge clk);
    chk("b_id_instr_hold", id_instr, 16'h1111);

    // Full with valid offered and decode ready: pop only.
    cyc(1'b1, 16'h4444, 16'h000A, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("c_id_instr", id_instr, 16'h2222);
    chk("c_if_ready", {15'd0, if_ready}, 16'd1);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("c_empty", {15'd0, id_valid}, 16'd0);

    // Halt instruction: stored, forwarded, and stops fetch.
    push(16'hF000, 16'h0010, 1'b0);
    idle();
    @(negedge clk);
    chk("d_halted", {15'd0, halted}, 16'd1);
    chk("d_if_ready", {15'd0, if_ready}, 16'd0);
    chk("d_id_instr", id_instr, 16'hF000);
    cyc(1'b1, 16'h5555, 16'h0012, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("d_ignore_instr", id_instr, 16'hF000);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("d_drained_valid", {15'd0, id_valid}, 16'd0);
    chk("d_still_halted", {15'd0, halted}, 16'd1);

    // Flush out of halt, refill to two with a halt, flush with a push.
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("e_resume", {15'd0, halted}, 16'd0);
    push(16'h6666, 16'h0020, 1'b0);
    push(16'hF001, 16'h0022, 1'b0);
    idle();
    @(negedge clk);
    chk("e_full_halted", {15'd0, halted}, 16'd1);
    chk("e_full_instr", id_instr, 16'h6666);
    cyc(1'b1, 16'h7777, 16'h0024, 1'b0, 1'b1);
    exp_q.delete();
    idle();
    @(negedge clk);
    chk("e_id_valid", {15'd0, id_valid}, 16'd0);
    chk("e_halted", {15'd0, halted}, 16'd0);
    chk("e_if_ready", {15'd0, if_ready}, 16'd1);
    chk("e_id_instr", id_instr, 16'h0000);

    // Flush coinciding with a halt push stays in RUN.
    cyc(1'b1, 16'hF002, 16'h0026, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("f_halted", {15'd0, halted}, 16'd0);
    chk("f_id_valid", {15'd0, id_valid}, 16'd0);

    // Simultaneous push and pop keeps one entry.
    push(16'h8888, 16'h0030, 1'b0);
    push(16'h9999, 16'h0032, 1'b1);
    idle();
    @(negedge clk);
    chk("g_id_instr", id_instr, 16'h9999);
    chk("g_id_pcs", id_pcs, 16'h0032);
    chk("g_if_ready", {15'd0, if_ready}, 16'd1);
    cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-cycle with two entries buffered.
    push(16'hAAAA, 16'h0040, 1'b0);
    push(16'hBBBB, 16'h0042, 1'b0);
    idle();
    @(negedge clk);
    chk("h_pre_valid", {15'd0, id_valid}, 16'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("h_id_valid", {15'd0, id_valid}, 16'd0);
    chk("h_id_instr", id_instr, 16'h0000);
    chk("h_if_ready", {15'd0, if_ready}, 16'd1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("h_post_valid", {15'd0, id_valid}, 16'd0);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
